lap_timer_ctrl: RTL and testbench

- Consumer of the track checkpoint tracker's `lap_finished` / `checkpoints_passed` levels.
- Runs the race sequence: idle, start countdown, racing, finished.
- Validates and counts laps, and times each lap in centiseconds.
- Publishes current, last and best lap times plus a lap counter to the HUD/overlay renderer. Single `pclk` domain.

---
 rtl/lap_timer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lap_timer_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/lap_timer_ctrl.sv
// Race sequencer for the HUD: countdown, lap validation and lap timing in ticks.
// Publishes current/last/best lap times and a lap counter, all registered on pclk.
module lap_timer_ctrl #(
   parameter int TICK_DIV      = 650000,
   parameter int TICKS_PER_SEC = 100,
   parameter int COUNT_SECS    = 3,
   parameter int NUM_LAPS      = 3,
   parameter int TIME_W        = 16
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              lap_finished,
   input  logic              checkpoints_passed,
   output logic [1:0]        countdown,
   output logic              race_active,
   output logic              race_done,
   output logic              lap_pulse,
   output logic [3:0]        lap_count,
   output logic [TIME_W-1:0] cur_time,
   output logic [TIME_W-1:0] last_time,
   output logic [TIME_W-1:0] best_time
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0]     SEC_MAX   = SW'(TICKS_PER_SEC - 1);
   localparam logic [1:0]        CD_INIT   = 2'(COUNT_SECS);
   localparam logic [3:0]        LAP_LAST  = 4'(NUM_LAPS - 1);
   localparam logic [TIME_W-1:0] TIME_ONES = {TIME_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_RACING    = 2'd2,
      ST_FINISHED  = 2'd3
   } state_t;

   state_t            state_r, state_nx_s;
   logic [PW-1:0]     presc_r, presc_nx_s;
   logic [SW-1:0]     sec_r, sec_nx_s;
   logic              lf_d_r;
   logic              tick_s, lap_valid_s;
   logic [1:0]        countdown_nx_s;
   logic              race_active_nx_s, race_done_nx_s, lap_pulse_nx_s;
   logic [3:0]        lap_count_nx_s;
   logic [TIME_W-1:0] cur_nx_s, last_nx_s, best_nx_s;

   assign tick_s      = ((state_r == ST_COUNTDOWN) || (state_r == ST_RACING)) && (presc_r == PRESC_MAX);
   // Only RACING consults this; a level already high on entry never produces an edge.
   assign lap_valid_s = lap_finished & ~lf_d_r & checkpoints_passed;

   // Next-state and next-output decode; abort overrides everything else.
   always_comb begin
      state_nx_s       = state_r;
      countdown_nx_s   = countdown;
      race_active_nx_s = race_active;
      race_done_nx_s   = race_done;
      lap_pulse_nx_s   = 1'b0;
      lap_count_nx_s   = lap_count;
      cur_nx_s         = cur_time;
      last_nx_s        = last_time;
      best_nx_s        = best_time;
      if (abort) begin
         state_nx_s       = ST_IDLE;
         race_active_nx_s = 1'b0;
         race_done_nx_s   = 1'b0;
         countdown_nx_s   = 2'd0;
         cur_nx_s         = '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_FINISHED: begin
               if (start) begin
                  state_nx_s       = ST_COUNTDOWN;
                  countdown_nx_s   = CD_INIT;
                  race_active_nx_s = 1'b0;
                  race_done_nx_s   = 1'b0;
                  lap_count_nx_s   = 4'd0;
                  cur_nx_s         = '0;
                  last_nx_s        = '0;
                  best_nx_s        = TIME_ONES;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_COUNTDOWN: begin
               if (tick_s && (sec_r == SEC_MAX)) begin
                  if (countdown <= 2'd1) begin
                     state_nx_s       = ST_RACING;
                     countdown_nx_s   = 2'd0;
                     race_active_nx_s = 1'b1;
                     cur_nx_s         = '0;
                  end else begin
                     countdown_nx_s = countdown - 2'd1;
                  end
               end else begin
                  countdown_nx_s = countdown;
               end
            end
            ST_RACING: begin
               if (lap_valid_s) begin
                  // The clear wins over a coincident tick; the recorded time is the pre-tick value.
                  last_nx_s      = cur_time;
                  best_nx_s      = (cur_time < best_time) ? cur_time : best_time;
                  cur_nx_s       = '0;
                  lap_count_nx_s = lap_count + 4'd1;
                  lap_pulse_nx_s = 1'b1;
                  if (lap_count == LAP_LAST) begin
                     state_nx_s       = ST_FINISHED;
                     race_active_nx_s = 1'b0;
                     race_done_nx_s   = 1'b1;
                  end else begin
                     state_nx_s = ST_RACING;
                  end
               end else if (tick_s && (cur_time != TIME_ONES)) begin
                  cur_nx_s = cur_time + TIME_W'(1);
               end else begin
                  cur_nx_s = cur_time;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
            end
         endcase
      end
   end

   // Prescaler and tick-per-second counter, both restarted on every state change.
   always_comb begin
      presc_nx_s = '0;
      sec_nx_s   = '0;
      if (state_nx_s != state_r) begin
         presc_nx_s = '0;
         sec_nx_s   = '0;
      end else if ((state_r == ST_COUNTDOWN) || (state_r == ST_RACING)) begin
         presc_nx_s = tick_s ? '0 : (presc_r + PW'(1));
         if ((state_r == ST_COUNTDOWN) && tick_s) begin
            sec_nx_s = (sec_r == SEC_MAX) ? '0 : (sec_r + SW'(1));
         end else begin
            sec_nx_s = sec_r;
         end
      end else begin
         presc_nx_s = '0;
         sec_nx_s   = '0;
      end
   end

   // State, counters and all outputs are registered here.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         presc_r     <= '0;
         sec_r       <= '0;
         lf_d_r      <= 1'b0;
         countdown   <= 2'd0;
         race_active <= 1'b0;
         race_done   <= 1'b0;
         lap_pulse   <= 1'b0;
         lap_count   <= 4'd0;
         cur_time    <= '0;
         last_time   <= '0;
         best_time   <= TIME_ONES;
      end else begin
         state_r     <= state_nx_s;
         presc_r     <= presc_nx_s;
         sec_r       <= sec_nx_s;
         lf_d_r      <= lap_finished;
         countdown   <= countdown_nx_s;
         race_active <= race_active_nx_s;
         race_done   <= race_done_nx_s;
         lap_pulse   <= lap_pulse_nx_s;
         lap_count   <= lap_count_nx_s;
         cur_time    <= cur_nx_s;
         last_time   <= last_nx_s;
         best_time   <= best_nx_s;
      end
   end

endmodule

// File: tb/tb_lap_timer_ctrl.sv
// Directed bench for lap_timer_ctrl with a short tick and countdown so a full race fits in a few hundred cycles.
module tb_lap_timer_ctrl;

   logic        pclk, rst_n, start, abort, lf, cp;
   logic [1:0]  countdown;
   logic        race_active, race_done, lap_pulse;
   logic [3:0]  lap_count;
   logic [15:0] cur_time, last_time, best_time;
   int          n_assert, n_fail;

   lap_timer_ctrl #(
      .TICK_DIV(2), .TICKS_PER_SEC(4), .COUNT_SECS(3), .NUM_LAPS(2), .TIME_W(16)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .start(start), .abort(abort),
      .lap_finished(lf), .checkpoints_passed(cp),
      .countdown(countdown), .race_active(race_active), .race_done(race_done),
      .lap_pulse(lap_pulse), .lap_count(lap_count), .cur_time(cur_time),
      .last_time(last_time), .best_time(best_time)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic check_outs(input string tag, input int cd, input int act, input int done,
                             input int pulse, input int cnt, input int cur, input int last,
                             input int best);
      check({tag, "_countdown"}, int'(countdown), cd);
      check({tag, "_active"}, int'(race_active), act);
      check({tag, "_done"}, int'(race_done), done);
      check({tag, "_pulse"}, int'(lap_pulse), pulse);
      check({tag, "_count"}, int'(lap_count), cnt);
      check({tag, "_cur"}, int'(cur_time), cur);
      check({tag, "_last"}, int'(last_time), last);
      check({tag, "_best"}, int'(best_time), best);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; lf = 1'b0; cp = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 65535);
      rst_n = 1'b1;
      step();
      check_outs("idle", 0, 0, 0, 0, 0, 0, 0, 65535);

      // Countdown: 8 cycles per second; a lap edge and a start pulse inside it are ignored.
      start = 1'b1;
      step();
      start = 1'b0;
      check_outs("cd_entry", 3, 0, 0, 0, 0, 0, 0, 65535);
      for (int k = 1; k < 24; k++) begin
         start = (k == 5);
         if (k == 10) begin lf = 1'b1; cp = 1'b1; end
         if (k == 12) begin lf = 1'b0; cp = 1'b0; end
         step();
         check_outs($sformatf("cd_k%0d", k), 3 - k / 8, 0, 0, 0, 0, 0, 0, 65535);
      end
      start = 1'b0;
      step();
      check_outs("race_entry", 0, 1, 0, 0, 0, 0, 0, 65535);

      // Finish-line crossing without checkpoints is not a lap.
      lf = 1'b1; cp = 1'b0;
      step();
      check_outs("cut_lap", 0, 1, 0, 0, 0, 0, 0, 65535);
      lf = 1'b0;
      repeat (3) step();
      check_outs("counting", 0, 1, 0, 0, 0, 2, 0, 65535);
      repeat (16) step();
      check_outs("pre_lap1", 0, 1, 0, 0, 0, 10, 0, 65535);

      lf = 1'b1; cp = 1'b1;
      step();
      check_outs("lap1", 0, 1, 0, 1, 1, 0, 10, 10);
      for (int r = 22; r <= 26; r++) begin
         step();
         check_outs($sformatf("lf_held_r%0d", r), 0, 1, 0, 0, 1, (r - 20) / 2, 10, 10);
      end
      lf = 1'b0; cp = 1'b0;
      repeat (8) step();
      check_outs("pre_lap2", 0, 1, 0, 0, 1, 7, 10, 10);

      lf = 1'b1; cp = 1'b1;
      step();
      check_outs("lap2_finish", 0, 0, 1, 1, 2, 0, 7, 7);
      lf = 1'b0;
      step();
      check_outs("fin_hold", 0, 0, 1, 0, 2, 0, 7, 7);
      lf = 1'b1;
      step();
      check_outs("fin_ignore", 0, 0, 1, 0, 2, 0, 7, 7);
      lf = 1'b0; cp = 1'b0;
      step();

      start = 1'b1;
      step();
      start = 1'b0;
      check_outs("restart", 3, 0, 0, 0, 0, 0, 0, 65535);
      repeat (24) step();
      check_outs("race2", 0, 1, 0, 0, 0, 0, 0, 65535);
      repeat (6) step();
      lf = 1'b1; cp = 1'b1;
      step();
      check_outs("lap_a", 0, 1, 0, 1, 1, 0, 3, 3);
      lf = 1'b0; cp = 1'b0;
      repeat (3) step();
      check_outs("pre_abort", 0, 1, 0, 0, 1, 2, 3, 3);

      // Abort beats a coincident valid lap edge.
      lf = 1'b1; cp = 1'b1; abort = 1'b1;
      step();
      check_outs("abort", 0, 0, 0, 0, 1, 0, 3, 3);
      abort = 1'b0; lf = 1'b0; cp = 1'b0;
      repeat (4) step();
      check_outs("idle_hold", 0, 0, 0, 0, 1, 0, 3, 3);

      start = 1'b1;
      step();
      start = 1'b0;
      check_outs("start_idle", 3, 0, 0, 0, 0, 0, 0, 65535);
      repeat (5) step();
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0, 65535);
      #10;
      rst_n = 1'b1;
      step();
      check_outs("post_rst", 0, 0, 0, 0, 0, 0, 0, 65535);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
